data_mem_interface: RTL and testbench

Data-side memory adapter between the compute core's M stage and the external data bus. It turns the core's single-cycle request (MemEn, MemWrite, ByteEn, MemAdr, MemWriteData) into a valid/ready bus transaction and stalls the core until the response arrives or times out. It returns registered read data on MemReadData. A small state machine sequences each access, and a timeout counter guards the bus.

---
 rtl/data_mem_interface_pkg.sv | 15 +
 rtl/data_mem_interface_if.sv | 40 ++++
 rtl/data_mem_interface_timer.sv | 29 ++
 rtl/data_mem_interface.sv | 101 ++++++++++
 tb/tb_data_mem_interface.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_interface_pkg.sv
// Shared types and defaults for the data-side memory adapter.
// The state enum sequences one bus access per core request.
package data_mem_interface_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } memIfState;

endpackage

// File: rtl/data_mem_interface_if.sv
// Valid/ready data bus between the adapter (master) and memory (slave).
interface data_mem_interface_if #(
    parameter int DATA_WIDTH = 32
);

    logic                    BusReqValid;
    logic                    BusReqReady;
    logic                    BusWrite;
    logic [DATA_WIDTH/8-1:0] BusByteEn;
    logic [DATA_WIDTH-1:0]   BusAdr;
    logic [DATA_WIDTH-1:0]   BusWriteData;
    logic                    BusRespValid;
    logic [DATA_WIDTH-1:0]   BusRespData;
    logic                    BusRespErr;

    modport master (
        output BusReqValid,
        output BusWrite,
        output BusByteEn,
        output BusAdr,
        output BusWriteData,
        input  BusReqReady,
        input  BusRespValid,
        input  BusRespData,
        input  BusRespErr
    );

    modport slave (
        input  BusReqValid,
        input  BusWrite,
        input  BusByteEn,
        input  BusAdr,
        input  BusWriteData,
        output BusReqReady,
        output BusRespValid,
        output BusRespData,
        output BusRespErr
    );

endinterface

// File: rtl/data_mem_interface_timer.sv
// Saturating wait-cycle counter; terminal count flags the bus timeout.
module data_mem_interface_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/data_mem_interface.sv
// Turns a single-cycle core data request into a bus transaction,
// stalling the core until the response or a timeout arrives.
module data_mem_interface
    import data_mem_interface_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemEn,
    input  logic                    MemWrite,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic [DATA_WIDTH-1:0]   MemAdr,
    input  logic [DATA_WIDTH-1:0]   MemWriteData,
    output logic [DATA_WIDTH-1:0]   MemReadData,
    output logic                    Stall,
    output logic                    Fault,
    data_mem_interface_if.master    bus
);

    memIfState               r_state;
    logic                    r_req_valid;
    logic                    r_write;
    logic [DATA_WIDTH/8-1:0] r_byte_en;
    logic [DATA_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_fault;
    logic                    w_tc;

    data_mem_interface_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (r_state == REQ),
        .i_enable(r_state == WAIT),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_valid <= 1'b0;
            r_write     <= 1'b0;
            r_byte_en   <= '0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (MemEn) begin
                        r_write     <= MemWrite;
                        r_byte_en   <= ByteEn;
                        r_adr       <= MemAdr;
                        r_wdata     <= MemWriteData;
                        r_req_valid <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.BusReqReady) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response on the terminal cycle still beats the timeout
                    if (bus.BusRespValid) begin
                        r_rdata <= (bus.BusRespErr || r_write) ?
                                   '0 : bus.BusRespData;
                        r_fault <= bus.BusRespErr;
                        r_state <= DONE;
                    end else if (w_tc) begin
                        r_rdata <= '0;
                        r_fault <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_fault <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Stall            = MemEn & (r_state != DONE);
    assign MemReadData      = r_rdata;
    assign Fault            = r_fault;
    assign bus.BusReqValid  = r_req_valid;
    assign bus.BusWrite     = r_write;
    assign bus.BusByteEn    = r_byte_en;
    assign bus.BusAdr       = r_adr;
    assign bus.BusWriteData = r_wdata;

endmodule

// File: tb/tb_data_mem_interface.sv
// Directed vector bench for data_mem_interface with a small bus responder.
module tb_data_mem_interface;

    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            MemEn = 1'b0;
    logic            MemWrite = 1'b0;
    logic [DW/8-1:0] ByteEn = '0;
    logic [DW-1:0]   MemAdr = '0;
    logic [DW-1:0]   MemWriteData = '0;
    logic [DW-1:0]   MemReadData;
    logic            Stall;
    logic            Fault;

    data_mem_interface_if #(.DATA_WIDTH(DW)) bus_if ();

    data_mem_interface #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemEn       (MemEn),
        .MemWrite    (MemWrite),
        .ByteEn      (ByteEn),
        .MemAdr      (MemAdr),
        .MemWriteData(MemWriteData),
        .MemReadData (MemReadData),
        .Stall       (Stall),
        .Fault       (Fault),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] adr;
        logic [31:0] wd;
        int          rdly;
        int          wdly;
        logic [31:0] rdata;
        logic        err;
        logic        nores;
        logic [31:0] exp_rd;
        logic        exp_flt;
        int          exp_stall;
    } vec_t;

    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;

    always @(posedge clk)
        if (bus_if.BusReqValid && bus_if.BusReqReady) accepts++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.BusReqReady  = 1'b0;
        bus_if.BusRespValid = 1'b0;
        bus_if.BusRespData  = '0;
        bus_if.BusRespErr   = 1'b0;
    endtask

    // Call at a falling edge with the adapter in IDLE.
    task automatic run_txn(input int id, input bit chain, input vec_t nv);
        vec_t v;
        int   stalls = 0, reqc = 0, waitc = 0, pre = 0, cyc = 0;
        bit   acc = 0, bad = 0, done = 0;
        v = vt[id];
        MemEn = 1'b1;
        MemWrite = v.wr;
        ByteEn = v.be;
        MemAdr = v.adr;
        MemWriteData = v.wd;
        while (!done && cyc < 60) begin
            #1;
            if (!Stall) begin
                done = 1;
            end else begin
                stalls++;
                if (bus_if.BusReqValid) begin
                    reqc++;
                    if (bus_if.BusWrite !== v.wr || bus_if.BusByteEn !== v.be ||
                        bus_if.BusAdr !== v.adr ||
                        bus_if.BusWriteData !== v.wd)
                        bad = 1;
                    bus_if.BusReqReady  = (reqc > v.rdly);
                    bus_if.BusRespValid = 1'b0;
                    if (reqc > v.rdly) acc = 1;
                end else begin
                    bus_if.BusReqReady = 1'b0;
                    if (acc) begin
                        waitc++;
                        bus_if.BusRespValid = !v.nores && (waitc > v.wdly);
                        bus_if.BusRespData  = v.rdata;
                        bus_if.BusRespErr   = v.err;
                    end else begin
                        if (reqc == 0) pre++;
                        bus_if.BusRespValid = 1'b0;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus_idle();
        chk($sformatf("v%0d_done", id), 32'(done), 32'd1);
        chk($sformatf("v%0d_stalls", id), 32'(stalls), 32'(v.exp_stall));
        chk($sformatf("v%0d_rdata", id), MemReadData, v.exp_rd);
        chk($sformatf("v%0d_fault", id), 32'(Fault), 32'(v.exp_flt));
        chk($sformatf("v%0d_busfields", id), 32'(bad), 32'd0);
        chk($sformatf("v%0d_idle_gap", id), 32'(pre), 32'd1);
        if (chain) begin
            MemWrite = nv.wr;
            ByteEn = nv.be;
            MemAdr = nv.adr;
            MemWriteData = nv.wd;
        end else begin
            MemEn = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_fault_pulse", id), 32'(Fault), 32'd0);
            chk($sformatf("v%0d_no_reissue", id),
                32'(bus_if.BusReqValid), 32'd0);
        end
    endtask

    initial begin
        int a0;
        // wr be adr wd rdly wdly rdata err nores exp_rd exp_flt exp_stall
        vt[0] = '{0, 4'hF, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0,
                  32'hDEADBEEF, 0, 3};
        vt[1] = '{1, 4'b0011, 32'h180, 32'h12345678, 4, 0, 32'hAAAA5555,
                  0, 0, 32'h0, 0, 7};
        vt[2] = '{0, 4'hF, 32'h200, 32'h0, 0, 0, 32'h77777777, 0, 1,
                  32'h0, 1, 10};
        vt[3] = '{0, 4'hF, 32'h204, 32'h0, 0, 0, 32'hFFFFFFFF, 1, 0,
                  32'h0, 1, 3};
        vt[4] = '{0, 4'hF, 32'h208, 32'h0, 0, 7, 32'hCAFEF00D, 0, 0,
                  32'hCAFEF00D, 0, 10};
        vt[5] = '{0, 4'hC, 32'h20C, 32'h0, 1, 2, 32'h0BADC0DE, 0, 0,
                  32'h0BADC0DE, 0, 6};
        vt[6] = '{0, 4'hF, 32'h0, 32'h0, 0, 0, 32'h11111111, 0, 0,
                  32'h11111111, 0, 3};
        vt[7] = '{0, 4'hF, 32'h4, 32'h0, 0, 0, 32'h22222222, 0, 0,
                  32'h22222222, 0, 3};

        bus_idle();
        #2;
        chk("rst_reqvalid", 32'(bus_if.BusReqValid), 32'd0);
        chk("rst_buswrite", 32'(bus_if.BusWrite), 32'd0);
        chk("rst_byteen", 32'(bus_if.BusByteEn), 32'd0);
        chk("rst_adr", bus_if.BusAdr, 32'd0);
        chk("rst_wdata", bus_if.BusWriteData, 32'd0);
        chk("rst_rdata", MemReadData, 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        MemEn = 1'b1;
        #1;
        chk("rst_stall_en", 32'(Stall), 32'd1);
        MemEn = 1'b0;
        #1;
        chk("rst_stall_dis", 32'(Stall), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(i, 1'b0, vt[0]);
            @(negedge clk);
        end

        a0 = accepts;
        run_txn(6, 1'b1, vt[7]);
        @(negedge clk);
        run_txn(7, 1'b0, vt[0]);
        chk("b2b_accepts", 32'(accepts - a0), 32'd2);
        @(negedge clk);

        // Reset while the request is still being offered
        MemEn = 1'b1;
        MemAdr = 32'h300;
        MemWrite = 1'b0;
        @(negedge clk);
        #1;
        chk("req_before_rst", 32'(bus_if.BusReqValid), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_req_drop", 32'(bus_if.BusReqValid), 32'd0);
        chk("rst_req_adr", bus_if.BusAdr, 32'd0);
        chk("rst_req_rdata", MemReadData, 32'd0);
        MemEn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset in WAIT, then a stale response must be ignored
        MemEn = 1'b1;
        MemAdr = 32'h304;
        @(negedge clk);
        bus_if.BusReqReady = 1'b1;
        @(negedge clk);
        bus_if.BusReqReady = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        MemEn = 1'b0;
        chk("rst_wait_reqvalid", 32'(bus_if.BusReqValid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_if.BusRespValid = 1'b1;
        bus_if.BusRespData  = 32'h5A5A5A5A;
        bus_if.BusRespErr   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stale_fault_%0d", c), 32'(Fault), 32'd0);
            chk($sformatf("stale_rdata_%0d", c), MemReadData, 32'd0);
        end
        bus_idle();
        @(negedge clk);
        run_txn(0, 1'b0, vt[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
